// File: rtl/cpu_pkg.sv
// Shared CPU-wide defaults for the fetch stage and the PC buffer state encoding.
package cpu_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;
    localparam int unsigned INC_DEF       = 4;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer that keeps a redirect target requested while the pipeline is stalled.
module pc_redirect_buf
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_target,
    output logic            valid,
    output logic [XLEN-1:0] target
);

    pend_state_t state;

    // Clear wins over load; a load while FULL simply overwrites the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PEND_EMPTY;
        end else begin
            case (state)
                PEND_EMPTY: if (load && !clear) state <= PEND_FULL;
                PEND_FULL:  if (clear)          state <= PEND_EMPTY;
                default:                        state <= PEND_EMPTY;
            endcase
        end
    end

    // Target carries no reset: it is only meaningful while valid is high.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            target <= load_target;
        end
    end

    assign valid = (state == PEND_FULL);

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: sequential advance, branch/exception redirects, stall-safe pending redirect.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0]  EXC_VEC   = XLEN'(EXC_VEC_DEF),
    parameter int unsigned      INC       = INC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_nostall,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            exc_valid,
    output logic [XLEN-1:0] IF_PC,
    output logic            IF_redirected,
    output logic            pend_valid
);

    logic [XLEN-1:0] redir_aligned;
    logic [XLEN-1:0] pend_target;
    logic            buf_load;
    logic            buf_clear;

    assign redir_aligned = redir_target & ~XLEN'(3);

    // Any advance consumes the entry; an exception discards it.
    assign buf_load  = redir_valid && !ID_nostall && !exc_valid;
    assign buf_clear = exc_valid || ID_nostall;

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .clear       (buf_clear),
        .load_target (redir_aligned),
        .valid       (pend_valid),
        .target      (pend_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_PC         <= RESET_VEC;
            IF_redirected <= 1'b0;
        end else if (exc_valid) begin
            IF_PC         <= EXC_VEC;
            IF_redirected <= 1'b1;
        end else if (ID_nostall && redir_valid) begin
            IF_PC         <= redir_aligned;
            IF_redirected <= 1'b1;
        end else if (ID_nostall && pend_valid) begin
            IF_PC         <= pend_target;
            IF_redirected <= 1'b1;
        end else if (ID_nostall) begin
            IF_PC         <= IF_PC + XLEN'(INC);
            IF_redirected <= 1'b0;
        end else begin
            IF_redirected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each step queues the expected IF outputs, then compares after the edge.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        ID_nostall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_valid;
    logic [31:0] IF_PC;
    logic        IF_redirected;
    logic        pend_valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ns;
        logic        rv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] pc;
        logic        red;
        logic        pv;
    } step_t;

    step_t sb[$];

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .EXC_VEC   (32'h0000_0180),
        .INC       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_nostall    (ID_nostall),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target),
        .exc_valid     (exc_valid),
        .IF_PC         (IF_PC),
        .IF_redirected (IF_redirected),
        .pend_valid    (pend_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic step_t s(input logic ns, input logic rv, input logic [31:0] tgt,
                                input logic ev, input logic [31:0] pc, input logic red,
                                input logic pv);
        step_t r;
        r.ns = ns; r.rv = rv; r.tgt = tgt; r.ev = ev;
        r.pc = pc; r.red = red; r.pv = pv;
        return r;
    endfunction

    task automatic cycle(input step_t st);
        @(negedge clk);
        ID_nostall   = st.ns;
        redir_valid  = st.rv;
        redir_target = st.tgt;
        exc_valid    = st.ev;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step_t e;
        rst = 1'b1; ID_nostall = 1'b0; redir_valid = 1'b0; redir_target = '0; exc_valid = 1'b0;
        sb.push_back(s(0, 0, 0, 0, 32'h0, 0, 0));
        #3;
        e = sb.pop_front();
        checks++;
        if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
            errors++;
            $display("FAIL reset: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                     IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        step_t t[4] = '{s(1,0,0,0,32'h4,0,0), s(1,0,0,0,32'h8,0,0),
                        s(1,0,0,0,32'hC,0,0), s(1,0,0,0,32'h10,0,0)};
        step_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL sequential[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_redirect;
        step_t t[3] = '{s(1,1,32'h103,0,32'h100,1,0), s(1,0,0,0,32'h104,0,0),
                        s(1,1,32'h20,0,32'h20,1,0)};
        step_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL redirect[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_stall_pending;
        step_t t[5] = '{s(0,0,0,0,32'h20,0,0), s(0,1,32'h400,0,32'h20,0,1),
                        s(0,0,0,0,32'h20,0,1), s(1,0,0,0,32'h400,1,0),
                        s(1,0,0,0,32'h404,0,0)};
        step_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL stall_pending[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_overwrite_and_exc;
        step_t t[7] = '{s(0,1,32'h400,0,32'h404,0,1), s(0,1,32'h800,0,32'h404,0,1),
                        s(1,0,0,0,32'h800,1,0),
                        s(0,1,32'h400,0,32'h800,0,1), s(0,0,0,1,32'h180,1,0),
                        s(0,0,0,0,32'h180,0,0), s(1,0,0,0,32'h184,0,0)};
        step_t e;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL overwrite_exc[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_simultaneous;
        step_t t[4] = '{s(1,1,32'h900,1,32'h180,1,0), s(1,0,0,0,32'h184,0,0),
                        s(0,1,32'h900,1,32'h180,1,0), s(1,0,0,0,32'h184,0,0)};
        step_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL simultaneous[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_back_to_back;
        step_t t[3] = '{s(1,1,32'h200,0,32'h200,1,0), s(1,1,32'h303,0,32'h300,1,0),
                        s(1,0,0,0,32'h304,0,0)};
        step_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_wrap;
        step_t t[3] = '{s(1,1,32'hFFFF_FFFF,0,32'hFFFF_FFFC,1,0), s(1,0,0,0,32'h0,0,0),
                        s(1,0,0,0,32'h4,0,0)};
        step_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(t[i]);
            cycle(t[i]);
            e = sb.pop_front();
            checks++;
            if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
                errors++;
                $display("FAIL wrap[%0d]: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                         i, IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
            end
        end
    endtask

    task automatic test_async_reset;
        step_t pre  = s(0, 1, 32'h400, 0, 32'h4, 0, 1);
        step_t post = s(1, 0, 0, 0, 32'h4, 0, 0);
        step_t e;
        sb.push_back(pre);
        cycle(pre);
        e = sb.pop_front();
        checks++;
        if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
            errors++;
            $display("FAIL async_reset_pre: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                     IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
        end
        @(negedge clk);
        redir_valid = 1'b0;
        #2;
        rst = 1'b1;
        sb.push_back(s(0, 0, 0, 0, 32'h0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
            errors++;
            $display("FAIL async_reset_mid: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                     IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(post);
        cycle(post);
        e = sb.pop_front();
        checks++;
        if ({IF_PC, IF_redirected, pend_valid} !== {e.pc, e.red, e.pv}) begin
            errors++;
            $display("FAIL async_reset_post: IF_PC=%h red=%b pend=%b, expected %h %b %b",
                     IF_PC, IF_redirected, pend_valid, e.pc, e.red, e.pv);
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_redirect;
        test_stall_pending;
        test_overwrite_and_exc;
        test_simultaneous;
        test_back_to_back;
        test_wrap;
        test_async_reset;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
